four_bank_mem: RTL and testbench
================================

// Module: four_bank_mem
// PURPOSE
//  Banked main-memory stage directly downstream of the cache controller.
//  Consumes the controller's Addr_mem/DataIn_mem/wr_mem/rd_mem and returns DataOut_mem.
//  Four word-interleaved banks (bank = addr[2:1]); each bank is busy for BANK_BUSY cycles after an access.
//  Fixed read latency; requests to a busy bank are stalled, never queued.
// PARAMETERS
//  DATA_W     16   data word width
//  ADDR_W     16   byte address width
//  ROW_W      13   row bits per bank (addr[15:3]); bank depth = 2**ROW_W words
//  RD_LAT     2    cycles from read accept to DataOut valid (>=1)
//  BANK_BUSY  4    cycles a bank stays busy, including the accept cycle (>=RD_LAT)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  Addr       in   ADDR_W  byte address of request (Addr_mem)
//  DataIn     in   DATA_W  write data (DataIn_mem)
//  wr         in   1       write request (wr_mem)
//  rd         in   1       read request (rd_mem)
//  DataOut    out  DATA_W  read data (to DataOut_mem); 0 when rd_valid=0
//  rd_valid   out  1       DataOut carries data for a read accepted RD_LAT cycles earlier
//  stall      out  1       combinational: request present but target bank busy; request dropped
//  busy       out  4       per-bank busy flags, bit i = bank i
//  err        out  1       illegal request flag
// BEHAVIOUR
//  Reset (rst_n=0, async): busy=0, all busy counters=0, read pipe flushed, rd_valid=0,
//   DataOut=0, err=0, stall=0. Array contents are NOT cleared; they survive reset.
//  Decode: bank=Addr[2:1], row=Addr[ROW_W+2:3]; upper bits beyond ROW_W+3 ignored (wrap).
//  Request = rd|wr. Illegal = (rd&wr) | Addr[0]. Illegal requests: err=1 that cycle, no array
//   access, no busy update, no read issued.
//  Accept = request & ~illegal & ~busy[bank]. stall = request & ~illegal & busy[bank].
//  Write accept: array[bank][row] <= DataIn at that edge; bank counter loads BANK_BUSY-1.
//  Read accept: array[bank][row] sampled at that edge into RD_LAT-deep pipe stage 1;
//   counter loads BANK_BUSY-1; DataOut/rd_valid appear exactly RD_LAT cycles after accept edge.
//  Busy counter per bank: nonzero => busy=1; decrements by 1 per cycle, saturates at 0.
//   With BANK_BUSY=4 a bank accessed at cycle t accepts again at cycle t+4.
//  Different banks are independent: back-to-back accesses to banks 0,1,2,3 on
//   consecutive cycles all accept (controller's 4-cycle writeback/fill bursts).
//  Pipe shifts every cycle; at most one read enters per cycle; no backpressure on output.
//  Read-after-write to same word: write at t, read accepted at >=t+BANK_BUSY returns new data.
//  Reset mid-read: in-flight read is discarded; rd_valid stays 0 after rst_n rises until a new read.
//  No request (rd=wr=0): no state change besides counter decrement and pipe shift.
// CONFIGURATION
//  FOUR_BANK_STICKY_ERR_EN defined: err is sticky, set by any illegal request, held until rst_n=0.
//  Not defined: err is combinational, high only in cycles with an illegal request.
//  Legality checks, access dropping and all other behaviour are identical in both builds.
// TESTING
//  1 Reset: rst_n low mid-cycle -> busy=0,rd_valid=0,DataOut=0,err=0 immediately (async).
//  2 Write 0xBEEF @0x1234 at t, read @0x1234 at t+4 -> rd_valid=1,DataOut=0xBEEF at t+6.
//  3 Burst wr @0x0100,0x0102,0x0104,0x0106 cycles t..t+3 -> stall=0 all, busy=4'b1111 at t+3;
//    then rd same four t+4..t+7 -> data out in order t+6..t+9.
//  4 wr @0x0200 at t, rd @0x0200 at t+1 -> stall=1, no rd_valid at t+3; retry t+4 accepted.
//  5 rd&wr together, or Addr=0x0201 -> err=1, busy unchanged, no array write; sticky build:
//    err stays 1 until reset; default build: err back to 0 next cycle.
//  6 Read accepted at t, rst_n low at t+1, released t+2 -> rd_valid never asserts; array keeps data.

Source files
------------

// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller and the banked main memory.
// The controller side uses the master modport; the memory uses the slave modport.
interface four_bank_mem_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] DataIn;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] DataOut;
  logic              rd_valid;
  logic              stall;
  logic [3:0]        busy;
  logic              err;

  modport master (
    output Addr, DataIn, wr, rd,
    input  DataOut, rd_valid, stall, busy, err
  );

  modport slave (
    input  Addr, DataIn, wr, rd,
    output DataOut, rd_valid, stall, busy, err
  );
endinterface

// File: rtl/four_bank_mem.sv
// Four word-interleaved memory banks with per-bank busy counters and a fixed-latency read pipe.
// Define FOUR_BANK_STICKY_ERR_EN to make err hold until reset instead of flagging per cycle.
module four_bank_mem #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned ROW_W     = 13,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned BANK_BUSY = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  four_bank_mem_if.slave bus
);

  localparam int unsigned CntW  = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
  localparam int unsigned Depth = 2 ** ROW_W;
  localparam logic [CntW-1:0] CntLoad = CntW'(BANK_BUSY - 1);

  // Contents are deliberately not reset so data survives rst_n.
  logic [DATA_W-1:0] mem_q [4][Depth];

  logic [CntW-1:0]   cnt_q [4];
  logic [CntW-1:0]   cnt_d [4];
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] pdata_q [RD_LAT];
  logic [DATA_W-1:0] pdata_d [RD_LAT];

  logic [1:0]       bank;
  logic [ROW_W-1:0] row;
  logic             req, illegal, accept;
  logic [3:0]       bank_busy;

  always_comb begin
    bank    = bus.Addr[2:1];
    row     = bus.Addr[ROW_W+2:3];
    req     = bus.rd | bus.wr;
    illegal = req & ((bus.rd & bus.wr) | bus.Addr[0]);
    for (int i = 0; i < 4; i++) begin
      bank_busy[i] = (cnt_q[i] != '0);
    end
    // Gated by rst_n so nothing is accepted while reset is held.
    accept = rst_n & req & ~illegal & ~bank_busy[bank];
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (accept && (bank == 2'(i))) begin
        cnt_d[i] = CntLoad;
      end else if (bank_busy[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    vld_d      = '0;
    pdata_d    = pdata_q;
    vld_d[0]   = accept & bus.rd;
    pdata_d[0] = mem_q[bank][row];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      pdata_d[i] = pdata_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < RD_LAT; i++) begin
        pdata_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pdata_q <= pdata_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      mem_q[bank][row] <= bus.DataIn;
    end
  end

`ifdef FOUR_BANK_STICKY_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  always_comb begin
    bus.err = rst_n & (err_q | illegal);
  end
`else
  always_comb begin
    bus.err = rst_n & illegal;
  end
`endif

  // The accepting bank reports busy in its accept cycle too.
  always_comb begin
    bus.stall    = rst_n & req & ~illegal & bank_busy[bank];
    bus.busy     = bank_busy | (accept ? (4'b0001 << bank) : 4'b0000);
    bus.rd_valid = vld_q[RD_LAT-1];
    bus.DataOut  = vld_q[RD_LAT-1] ? pdata_q[RD_LAT-1] : '0;
  end

endmodule

// File: tb/tb_four_bank_mem.sv
// Directed and random checks of four_bank_mem against a cycle-numbered reference model
// built from bank free times, a word-addressed memory map and a queue of due read returns.
module tb_four_bank_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  four_bank_mem_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  four_bank_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } rd_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          free_at [4];
  logic [15:0] mem_m [int];
  rd_t         pend [$];
  bit          err_sticky = 0;

  // Decisions made at the check point, applied at the following rising edge.
  bit          m_acc, m_ill, m_rd, m_wr;
  logic [15:0] m_addr, m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    pend.delete();
    err_sticky = 0;
  endtask

  task automatic check_cycle();
    bit          req, bsy, exp_v, known, exp_err;
    logic [3:0]  exp_busy;
    logic [15:0] exp_d;
    int          b;
    m_rd   = bus.rd;
    m_wr   = bus.wr;
    m_addr = bus.Addr;
    m_data = bus.DataIn;
    req    = m_rd | m_wr;
    m_ill  = req && ((m_rd && m_wr) || m_addr[0]);
    b      = int'(m_addr[2:1]);
    bsy    = cyc < free_at[b];
    m_acc  = req && !m_ill && !bsy;
    for (int i = 0; i < 4; i++) exp_busy[i] = (cyc < free_at[i]) || (m_acc && i == b);
`ifdef FOUR_BANK_STICKY_ERR_EN
    exp_err = err_sticky || m_ill;
`else
    exp_err = m_ill;
`endif
    exp_v = 0;
    known = 0;
    exp_d = '0;
    foreach (pend[k]) begin
      if (pend[k].due == cyc) begin
        exp_v = 1;
        known = pend[k].known;
        exp_d = pend[k].data;
      end
    end
    chk("stall", 32'(bus.stall), 32'(req && !m_ill && bsy));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("err", 32'(bus.err), 32'(exp_err));
    chk("rd_valid", 32'(bus.rd_valid), 32'(exp_v));
    if (!exp_v || known) chk("DataOut", 32'(bus.DataOut), 32'(exp_d));
  endtask

  task automatic model_update();
    rd_t e;
    int  w;
    w = int'(m_addr[15:1]);
    if (m_ill) err_sticky = 1;
    if (m_acc) begin
      free_at[m_addr[2:1]] = cyc + 4;
      if (m_wr) begin
        mem_m[w] = m_data;
      end else begin
        e.due   = cyc + 2;
        e.known = mem_m.exists(w);
        e.data  = e.known ? mem_m[w] : 16'h0;
        pend.push_back(e);
      end
    end
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    cyc++;
  endtask

  // Entered #1 after a rising edge; leaves #1 after the next rising edge.
  task automatic step(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    bus.rd     = r;
    bus.wr     = w;
    bus.Addr   = a;
    bus.DataIn = d;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] a;
    int          sel;
    bus.rd     = 0;
    bus.wr     = 0;
    bus.Addr   = '0;
    bus.DataIn = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Write then read the same word after the bank frees.
    step(0, 1, 16'h1234, 16'hBEEF);
    idle(3);
    step(1, 0, 16'h1234, 16'h0);
    idle(3);

    // Burst across all four banks, then read back in order.
    for (int i = 0; i < 4; i++) step(0, 1, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i));
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0100 + 16'(2 * i), 16'h0);
    idle(3);

    // Same-bank conflict stalls, retry after the busy window.
    step(0, 1, 16'h0200, 16'h5A5A);
    step(1, 0, 16'h0200, 16'h0);
    idle(2);
    step(1, 0, 16'h0200, 16'h0);
    idle(4);

    // Illegal requests must not touch the array or busy state.
    step(1, 1, 16'h0200, 16'h1111);
    step(0, 1, 16'h0201, 16'h2222);
    idle(1);
    step(1, 0, 16'h0200, 16'h0);
    idle(3);

    // Reset while a read is in flight.
    step(1, 0, 16'h1234, 16'h0);
    bus.rd = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_DataOut", 32'(bus.DataOut), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    step(1, 0, 16'h1234, 16'h0);
    idle(3);

    // Randomized traffic over a small word pool to provoke conflicts and read-after-write.
    for (int i = 0; i < 300; i++) begin
      a   = 16'h0300 + 16'(2 * $urandom_range(0, 7));
      sel = int'($urandom_range(0, 15));
      if (sel == 0) a[0] = 1'b1;
      if (sel <= 4) step(0, 0, a, 16'h0);
      else if (sel <= 9) step(0, 1, a, 16'($urandom));
      else if (sel == 10) step(1, 1, a, 16'($urandom));
      else step(1, 0, a, 16'h0);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
